serial_frame_deser: RTL and testbench

- Downstream consumer of the single-bit registered data stream (flop `q` output).
- Frames the stream as: start bit (1), WIDTH data bits LSB first, stop bit (0).
- Assembles each frame into a parallel word and presents it on a valid/ready output port.
- Flags framing errors and overruns. Sits between the bit-level flop stage and word-level logic.

---
 rtl/serial_frame_deser_if.sv | 24 ++
 rtl/serial_frame_deser.sv | 111 +++++++++++
 tb/tb_serial_frame_deser.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/serial_frame_deser_if.sv
// Bit-stream in / word-out handshake bundle for serial_frame_deser.
// master drives the serial line and the consumer ready; slave is the deserializer.
interface serial_frame_deser_if #(
  parameter int WIDTH = 8
);
  logic             din;
  logic             din_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  modport master (
    output din, din_en, dout_ready,
    input  dout, dout_valid, frame_err, overrun, busy
  );

  modport slave (
    input  din, din_en, dout_ready,
    output dout, dout_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/serial_frame_deser.sv
// Serial frame deserializer: start(1), WIDTH data bits LSB first, stop(0).
// Good frames land in a one-deep valid/ready slot; framing errors and overruns pulse for one cycle.
module serial_frame_deser #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_frame_deser_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] dout_q, dout_nxt;
  logic             valid_q, valid_nxt;
  logic             ferr_q, ferr_nxt;
  logic             ovr_q, ovr_nxt;
  logic             busy_q;
  logic             good_stop, bad_stop, slot_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shreg   <= shreg_nxt;
      dout_q  <= dout_nxt;
      valid_q <= valid_nxt;
      ferr_q  <= ferr_nxt;
      ovr_q   <= ovr_nxt;
      busy_q  <= (state_nxt != IDLE);
    end
  end

  // Frame FSM advances only on enabled samples.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    if (bus.din_en) begin
      case (state)
        IDLE: begin
          if (bus.din) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
          end
        end
        DATA: begin
          shreg_nxt[cnt] = bus.din;
          cnt_nxt        = cnt + 1'b1;
          if (cnt == LAST) begin
            state_nxt = STOP;
            cnt_nxt   = '0;
          end
        end
        STOP: begin
          good_stop = ~bus.din;
          bad_stop  = bus.din;
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // The slot counts as free when it is empty or being drained on this same edge.
  always_comb begin
    slot_free = ~valid_q | bus.dout_ready;
    dout_nxt  = dout_q;
    valid_nxt = valid_q & ~bus.dout_ready;
    ferr_nxt  = bad_stop;
    ovr_nxt   = 1'b0;
    if (good_stop) begin
      if (slot_free) begin
        dout_nxt  = shreg;
        valid_nxt = 1'b1;
      end else begin
        ovr_nxt   = 1'b1;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_deser.sv
// Self-checking bench for serial_frame_deser: directed scenarios then randomized frames
// checked against a frame-level model of the output slot.
module tb_serial_frame_deser;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_asrt;
  int   n_fail;

  logic [W-1:0] exp_dout;
  logic         exp_valid;
  logic [W-1:0] cur_word;

  serial_frame_deser_if #(.WIDTH(W)) bus ();

  serial_frame_deser #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input logic ef, input logic eo, input logic eb);
    chk("dout_valid", 32'(bus.dout_valid), 32'(exp_valid));
    chk("dout",       32'(bus.dout),       32'(exp_dout));
    chk("frame_err",  32'(bus.frame_err),  32'(ef));
    chk("overrun",    32'(bus.overrun),    32'(eo));
    chk("busy",       32'(bus.busy),       32'(eb));
  endtask

  function automatic logic pick(input int m);
    if (m == 2) return logic'($urandom_range(0, 1));
    return m[0];
  endfunction

  // One clock: drive at negedge, model the slot at posedge, check at next negedge.
  task automatic cyc(input logic d, input logic en, input logic rdy, input bit is_stop, input bit ebusy);
    logic ef, eo, free;
    ef = 1'b0;
    eo = 1'b0;
    bus.din        = d;
    bus.din_en     = en;
    bus.dout_ready = rdy;
    @(posedge clk);
    free = !exp_valid || rdy;
    if (is_stop && en && d) begin
      ef = 1'b1;
      if (exp_valid && rdy) exp_valid = 1'b0;
    end else if (is_stop && en && free) begin
      exp_dout  = cur_word;
      exp_valid = 1'b1;
    end else begin
      if (is_stop && en) eo = 1'b1;
      if (exp_valid && rdy) exp_valid = 1'b0;
    end
    @(negedge clk);
    chk_all(ef, eo, ebusy);
  endtask

  // gaps: 0 none, 1 one disabled cycle before every bit, 2 random disabled cycles.
  task automatic send_frame(input logic [W-1:0] w, input logic stop, input int gaps,
                            input int rmode, input int srmode);
    logic [W+1:0] bits;
    bits     = {stop, w, 1'b1};
    cur_word = w;
    for (int i = 0; i < W + 2; i++) begin
      if (gaps == 1)
        cyc(logic'($urandom_range(0, 1)), 1'b0, pick(rmode), 1'b0, i > 0);
      else if (gaps == 2)
        while ($urandom_range(0, 2) == 0)
          cyc(logic'($urandom_range(0, 1)), 1'b0, pick(rmode), 1'b0, i > 0);
      cyc(bits[i], 1'b1, (i == W + 1) ? pick(srmode) : pick(rmode), i == W + 1, i < W + 1);
    end
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    exp_dout  = '0;
    exp_valid = 1'b0;
    cur_word  = '0;
    rst = 1'b1;
    bus.din = 1'b0;
    bus.din_en = 1'b0;
    bus.dout_ready = 1'b0;
    #1;
    chk_all(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // basic frame, then valid drains with ready held
    send_frame(8'hA5, 1'b0, 0, 1, 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // framing error leaves slot untouched; 0x3C never appears
    send_frame(8'h3C, 1'b1, 0, 1, 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // overrun: second word dropped, first held, then drained alone
    send_frame(8'h11, 1'b0, 0, 0, 0);
    send_frame(8'h22, 1'b0, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // simultaneous drain and load on the stop edge
    send_frame(8'h11, 1'b0, 0, 0, 0);
    send_frame(8'h22, 1'b0, 0, 0, 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // gapped enable
    send_frame(8'h5A, 1'b0, 1, 1, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // reset after four data bits: everything clears at once, no pulses
    exp_valid = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(logic'(i % 2), 1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    exp_dout  = '0;
    exp_valid = 1'b0;
    chk_all(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'hC3, 1'b0, 0, 1, 1);

    // back-to-back, no idle bits
    send_frame(8'h01, 1'b0, 0, 1, 1);
    send_frame(8'hFF, 1'b0, 0, 1, 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // no automatic resync after a bad stop: a 1 right after is a start bit
    send_frame(8'h96, 1'b1, 0, 1, 1);
    send_frame(8'h69, 1'b0, 0, 1, 1);

    // randomized frames, enables, idle bits, ready and stop errors
    for (int f = 0; f < 60; f++) begin
      int idle;
      idle = int'($urandom_range(0, 3));
      for (int k = 0; k < idle; k++) begin
        if ($urandom_range(0, 1) == 1) cyc(1'b0, 1'b1, pick(2), 1'b0, 1'b0);
        else cyc(logic'($urandom_range(0, 1)), 1'b0, pick(2), 1'b0, 1'b0);
      end
      send_frame(W'($urandom), ($urandom_range(0, 5) == 0), int'($urandom_range(0, 2)), 2, 2);
    end
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
